// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
// Computes PC+4, reads the boot-image instruction ROM and latches both into
// the IF/ID pipeline register, honouring the stall (IFIDWrite) and the
// branch/jump squash (IF_Flush). TYPE classifies the latched instruction.
//
// Ports:
//   CLK            pipeline clock, IF/ID updates on the rising edge
//   RESET          asynchronous active-high reset
//   PC             current fetch address
//   IFIDWrite      1 = load IF/ID, 0 = hold
//   IF_Flush       1 = squash the instruction being latched
//   IF_PC_4        PC + 4 (combinational)
//   IF_Instruction ROM word at PC (combinational)
//   ID_Instruction registered instruction
//   ID_PC_4        registered PC + 4
//   FLUSH          registered, 1 = ID slot holds a squashed bubble
//   TYPE           class of ID_Instruction (combinational)
module if_fetch_stage #(
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  input  logic        IFIDWrite,
  input  logic        IF_Flush,
  output logic [31:0] IF_PC_4,
  output logic [31:0] IF_Instruction,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PC_4,
  output logic        FLUSH,
  output logic [2:0]  TYPE
);

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_RTYPE  = 3'd1,
    CLS_IALU   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_OTHER  = 3'd7
  } instr_class_e;

  instr_class_e id_class;
  logic [31:0]  word_idx;
  logic [31:0]  rom_word;

  assign IF_PC_4  = PC + 32'd4;
  assign word_idx = {2'b00, PC[31:2]};

  // The ROM has no write port, so the image that reset would load is simply
  // the constant contents; a table lookup is observably identical.
  always_comb begin
    rom_word = '0;
    if (word_idx < MEM_DEPTH) begin
      unique case (word_idx)
        32'd0:   rom_word = 32'h23BD_FFF0;
        32'd1:   rom_word = 32'h2010_0008;
        32'd2:   rom_word = 32'hAFB0_0000;
        32'd3:   rom_word = 32'h8FB1_0000;
        32'd5:   rom_word = 32'h1211_0002;
        32'd6:   rom_word = 32'h0800_0000;
        default: rom_word = '0;
      endcase
    end
  end

  assign IF_Instruction = rom_word;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ID_Instruction <= '0;
      ID_PC_4        <= '0;
      FLUSH          <= 1'b0;
    end else if (IF_Flush) begin
      ID_Instruction <= '0;
      ID_PC_4        <= '0;
      FLUSH          <= 1'b1;
    end else if (IFIDWrite) begin
      ID_Instruction <= IF_Instruction;
      ID_PC_4        <= IF_PC_4;
      FLUSH          <= 1'b0;
    end
  end

  always_comb begin
    id_class = CLS_OTHER;
    unique case (ID_Instruction[31:26])
      6'h00:   id_class = (ID_Instruction == '0) ? CLS_NOP : CLS_RTYPE;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:
               id_class = CLS_IALU;
      6'h23:   id_class = CLS_LOAD;
      6'h2B:   id_class = CLS_STORE;
      6'h04, 6'h05:
               id_class = CLS_BRANCH;
      6'h02, 6'h03:
               id_class = CLS_JUMP;
      default: id_class = CLS_OTHER;
    endcase
  end

  assign TYPE = id_class;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic        IFIDWrite;
  logic        IF_Flush;
  logic [31:0] IF_PC_4;
  logic [31:0] IF_Instruction;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PC_4;
  logic        FLUSH;
  logic [2:0]  TYPE;

  if_fetch_stage #(.MEM_DEPTH(64)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .PC(PC),
    .IFIDWrite(IFIDWrite),
    .IF_Flush(IF_Flush),
    .IF_PC_4(IF_PC_4),
    .IF_Instruction(IF_Instruction),
    .ID_Instruction(ID_Instruction),
    .ID_PC_4(ID_PC_4),
    .FLUSH(FLUSH),
    .TYPE(TYPE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        wr;
    logic        fl;
    logic [31:0] exp_if_instr;
    logic [31:0] exp_if_pc4;
    logic [31:0] exp_id_instr;
    logic [31:0] exp_id_pc4;
    logic        exp_flush;
    logic [2:0]  exp_type;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] pc, input logic wr, input logic fl,
                     input logic [31:0] ii, input logic [31:0] ip,
                     input logic [31:0] di, input logic [31:0] dp,
                     input logic df, input logic [2:0] ty);
    vec_t v;
    v.pc = pc; v.wr = wr; v.fl = fl;
    v.exp_if_instr = ii; v.exp_if_pc4 = ip;
    v.exp_id_instr = di; v.exp_id_pc4 = dp;
    v.exp_flush = df; v.exp_type = ty;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge CLK);
    PC = v.pc; IFIDWrite = v.wr; IF_Flush = v.fl;
    #1;
    chk($sformatf("v%0d IF_Instruction", idx), IF_Instruction, v.exp_if_instr);
    chk($sformatf("v%0d IF_PC_4", idx), IF_PC_4, v.exp_if_pc4);
    @(posedge CLK);
    #1;
    chk($sformatf("v%0d ID_Instruction", idx), ID_Instruction, v.exp_id_instr);
    chk($sformatf("v%0d ID_PC_4", idx), ID_PC_4, v.exp_id_pc4);
    chk($sformatf("v%0d FLUSH", idx), {31'b0, FLUSH}, {31'b0, v.exp_flush});
    chk($sformatf("v%0d TYPE", idx), {29'b0, TYPE}, {29'b0, v.exp_type});
  endtask

  initial begin
    //   pc            wr  fl  IF_Instr      IF_PC_4       ID_Instr      ID_PC_4       FL  TYPE
    add(32'h0000_0000, 1, 0, 32'h23BDFFF0, 32'h00000004, 32'h23BDFFF0, 32'h00000004, 0, 3'd2);
    add(32'h0000_0004, 1, 0, 32'h20100008, 32'h00000008, 32'h20100008, 32'h00000008, 0, 3'd2);
    add(32'h0000_0008, 1, 0, 32'hAFB00000, 32'h0000000C, 32'hAFB00000, 32'h0000000C, 0, 3'd4);
    add(32'h0000_000C, 1, 0, 32'h8FB10000, 32'h00000010, 32'h8FB10000, 32'h00000010, 0, 3'd3);
    add(32'h0000_0010, 1, 0, 32'h00000000, 32'h00000014, 32'h00000000, 32'h00000014, 0, 3'd0);
    add(32'h0000_0014, 1, 0, 32'h12110002, 32'h00000018, 32'h12110002, 32'h00000018, 0, 3'd5);
    add(32'h0000_0018, 1, 0, 32'h08000000, 32'h0000001C, 32'h08000000, 32'h0000001C, 0, 3'd6);
    // ignored low PC bits
    add(32'h0000_0007, 1, 0, 32'h20100008, 32'h0000000B, 32'h20100008, 32'h0000000B, 0, 3'd2);
    // stall for two edges
    add(32'h0000_0004, 1, 0, 32'h20100008, 32'h00000008, 32'h20100008, 32'h00000008, 0, 3'd2);
    add(32'h0000_0010, 0, 0, 32'h00000000, 32'h00000014, 32'h20100008, 32'h00000008, 0, 3'd2);
    add(32'h0000_0010, 0, 0, 32'h00000000, 32'h00000014, 32'h20100008, 32'h00000008, 0, 3'd2);
    // flush overrides stall, then one-cycle bubble
    add(32'h0000_0000, 0, 1, 32'h23BDFFF0, 32'h00000004, 32'h00000000, 32'h00000000, 1, 3'd0);
    add(32'h0000_0000, 1, 0, 32'h23BDFFF0, 32'h00000004, 32'h23BDFFF0, 32'h00000004, 0, 3'd2);
    // bounds
    add(32'h0000_0100, 1, 0, 32'h00000000, 32'h00000104, 32'h00000000, 32'h00000104, 0, 3'd0);
    add(32'hFFFF_FFFC, 1, 0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0, 3'd0);
    // flush, then stall: FLUSH holds its value
    add(32'h0000_0008, 1, 0, 32'hAFB00000, 32'h0000000C, 32'hAFB00000, 32'h0000000C, 0, 3'd4);
    add(32'h0000_0008, 0, 1, 32'hAFB00000, 32'h0000000C, 32'h00000000, 32'h00000000, 1, 3'd0);
    add(32'h0000_0008, 0, 0, 32'hAFB00000, 32'h0000000C, 32'h00000000, 32'h00000000, 1, 3'd0);
    add(32'h0000_0008, 1, 0, 32'hAFB00000, 32'h0000000C, 32'hAFB00000, 32'h0000000C, 0, 3'd4);

    RESET = 1'b1; PC = '0; IFIDWrite = 1'b0; IF_Flush = 1'b0;
    #12;
    chk("reset ID_Instruction", ID_Instruction, 32'h0);
    chk("reset ID_PC_4", ID_PC_4, 32'h0);
    chk("reset FLUSH", {31'b0, FLUSH}, 32'h0);
    chk("reset TYPE", {29'b0, TYPE}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Mid-cycle reset with register loaded and FLUSH set
    @(negedge CLK);
    PC = 32'h0000_0014; IFIDWrite = 1'b1; IF_Flush = 1'b0;
    @(posedge CLK); #1;
    chk("pre-reset ID_Instruction", ID_Instruction, 32'h12110002);
    @(negedge CLK);
    IFIDWrite = 1'b0; IF_Flush = 1'b1;
    @(posedge CLK); #1;
    chk("pre-reset FLUSH", {31'b0, FLUSH}, 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    chk("async reset ID_Instruction", ID_Instruction, 32'h0);
    chk("async reset ID_PC_4", ID_PC_4, 32'h0);
    chk("async reset FLUSH", {31'b0, FLUSH}, 32'h0);
    chk("async reset TYPE", {29'b0, TYPE}, 32'h0);
    IF_Flush = 1'b0;
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    PC = 32'h0000_000C; IFIDWrite = 1'b1;
    #1;
    chk("post-reset IF_Instruction", IF_Instruction, 32'h8FB10000);
    @(posedge CLK); #1;
    chk("post-reset ID_Instruction", ID_Instruction, 32'h8FB10000);
    chk("post-reset ID_PC_4", ID_PC_4, 32'h00000010);
    chk("post-reset TYPE", {29'b0, TYPE}, 32'd3);
    chk("post-reset FLUSH", {31'b0, FLUSH}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
